// File: rtl/alu_4bit_if.sv
// Operand/result bus for alu_4bit: the master drives operands and opcode,
// and the slave returns the registered result.
interface alu_4bit_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       opcode;
    logic [WIDTH:0]   C;

    modport master (output A, output B, output opcode, input C);
    modport slave  (input A, input B, input opcode, output C);
endinterface

// File: rtl/alu_4bit.sv
// Registered unsigned ALU: add, subtract, and, or with one-cycle latency.
// C[WIDTH] is carry (add), borrow (sub) or 0 (logic ops).
module alu_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_4bit_if.slave  bus
);
    localparam int unsigned CW = WIDTH + 1;

    logic [CW-1:0] a_ext;
    logic [CW-1:0] b_ext;
    logic [CW-1:0] result_c;

    assign a_ext = CW'(bus.A);
    assign b_ext = CW'(bus.B);

    // Full decode; subtraction wraps at WIDTH+1 bits so the MSB is the borrow.
    always_comb begin
        result_c = '0;
        case (bus.opcode)
            2'b00:   result_c = a_ext + b_ext;
            2'b01:   result_c = a_ext - b_ext;
            2'b10:   result_c = a_ext & b_ext;
            default: result_c = a_ext | b_ext;
        endcase
    end

    // Synchronous active-low reset wins over the computed result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.C <= '0;
        end else begin
            bus.C <= result_c;
        end
    end
endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: a scoreboard queue holds the expected
// result for each driven vector, and it is compared one edge later.
module tb_alu_4bit;
    localparam int unsigned WIDTH = 4;

    logic clk;
    logic rst;

    alu_4bit_if #(.WIDTH(WIDTH)) bus ();

    alu_4bit #(.WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned total;
    int unsigned bad;
    logic [4:0]  exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Reference model in integer arithmetic, independent of bit-level tricks.
    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
        int r;
        case (op)
            2'b00:   r = int'(a) + int'(b);
            2'b01:   begin
                r = int'(a) - int'(b);
                if (r < 0) r += 32;
            end
            2'b10:   r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return 5'(r);
    endfunction

    // One vector per cycle: drive at negedge, check just after the capturing
    // posedge, then disturb inputs and rst mid-cycle and confirm C holds.
    task automatic step(input string tag, input logic r, input logic [3:0] a,
                        input logic [3:0] b, input logic [1:0] op);
        logic [4:0] exp;
        @(negedge clk);
        rst        = r;
        bus.A      = a;
        bus.B      = b;
        bus.opcode = op;
        exp_q.push_back(r ? model(a, b, op) : 5'b00000);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check(tag, bus.C, exp);
        bus.A      = ~a;
        bus.B      = ~b;
        bus.opcode = ~op;
        rst        = ~r;
        #2;
        check({tag, "_hold"}, bus.C, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst        = 1'b0;
        bus.A      = 4'hF;
        bus.B      = 4'hF;
        bus.opcode = 2'b00;

        step("rst0", 1'b0, 4'hF, 4'hF, 2'b00);
        step("rst1", 1'b0, 4'hF, 4'hF, 2'b00);

        step("add_2_1",   1'b1, 4'd2,  4'd1,  2'b00);
        step("add_15_15", 1'b1, 4'd15, 4'd15, 2'b00);
        step("add_0_0",   1'b1, 4'd0,  4'd0,  2'b00);
        step("sub_4_3",   1'b1, 4'd4,  4'd3,  2'b01);
        step("sub_3_4",   1'b1, 4'd3,  4'd4,  2'b01);
        step("sub_0_15",  1'b1, 4'd0,  4'd15, 2'b01);
        step("sub_eq",    1'b1, 4'd7,  4'd7,  2'b01);
        step("and_9_6",   1'b1, 4'd9,  4'd6,  2'b10);
        step("or_15_10",  1'b1, 4'd15, 4'd10, 2'b11);
        step("and_15_10", 1'b1, 4'd15, 4'd10, 2'b10);

        for (int i = 0; i < 10; i++) begin
            step($sformatf("rand%0d", i), 1'b1, 4'($urandom_range(15)),
                 4'($urandom_range(15)), 2'($urandom_range(3)));
        end

        step("mid_add_a",  1'b1, 4'd3, 4'd4, 2'b00);
        step("mid_rst",    1'b0, 4'd5, 4'd5, 2'b00);
        step("mid_add_b",  1'b1, 4'd6, 4'd7, 2'b00);

        for (int op = 0; op < 4; op++) begin
            for (int i = 0; i < 4; i++) begin
                step($sformatf("op%0d_%0d", op, i), 1'b1, 4'($urandom_range(15)),
                     4'($urandom_range(15)), 2'(op));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
